// File: rtl/csa_pkg.sv
// Shared sizing helpers and parameter legality check for the pipelined carry-select adder.
package csa_pkg;

  localparam int unsigned CSA_WIDTH_DEF = 12;
  localparam int unsigned CSA_BLOCK_DEF = 4;
  localparam int unsigned CSA_GROUP_DEF = 1;

  // Number of BLOCK-bit slices across the operand.
  function automatic int unsigned csa_nslice(input int unsigned width, input int unsigned block);
    return (block == 0) ? 0 : width / block;
  endfunction

  // Pipeline depth: one stage per GROUP slices, last stage may be partial.
  function automatic int unsigned csa_lat(input int unsigned nslice, input int unsigned group);
    return (group == 0) ? 0 : (nslice + group - 1) / group;
  endfunction

  function automatic bit csa_params_ok(input int unsigned width, input int unsigned block,
                                       input int unsigned group);
    if (width == 0 || block == 0) return 1'b0;
    if (width % block != 0) return 1'b0;
    return (group >= 1) && (group <= width / block);
  endfunction

endpackage

// File: rtl/csa_slice.sv
// Carry-select slice: a BLOCK-bit ripple pair precomputed for carry-in 0 and 1, then
// muxed by the live carry. DUAL=0 gives a plain ripple slice for the first slice.
module csa_slice #(
  parameter int unsigned BLOCK = 4,
  parameter bit          DUAL  = 1'b1
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  if (DUAL) begin : g_dual
    logic [BLOCK-1:0] s0;
    logic [BLOCK-1:0] s1;
    logic             c0;
    logic             c1;

    always_comb begin : p_ripple
      logic r0;
      logic r1;
      s0 = '0;
      s1 = '0;
      r0 = 1'b0;
      r1 = 1'b1;
      for (int i = 0; i < int'(BLOCK); i++) begin
        s0[i] = a[i] ^ b[i] ^ r0;
        s1[i] = a[i] ^ b[i] ^ r1;
        r0    = (a[i] & b[i]) | (r0 & (a[i] ^ b[i]));
        r1    = (a[i] & b[i]) | (r1 & (a[i] ^ b[i]));
      end
      c0 = r0;
      c1 = r1;
    end

    assign sum  = cin ? s1 : s0;
    assign cout = c0 | (c1 & cin);
  end else begin : g_single
    always_comb begin : p_ripple
      logic r;
      sum = '0;
      r   = cin;
      for (int i = 0; i < int'(BLOCK); i++) begin
        sum[i] = a[i] ^ b[i] ^ r;
        r      = (a[i] & b[i]) | (r & (a[i] ^ b[i]));
      end
      cout = r;
    end
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake on both sides.
// Each stage finishes GROUP slices and skews the untouched upper operand bits forward.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH_DEF,
  parameter int unsigned BLOCK = CSA_BLOCK_DEF,
  parameter int unsigned GROUP = CSA_GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_carry,
  input  logic             i_sub,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int unsigned NSLICE = csa_nslice(WIDTH, BLOCK);
  localparam int unsigned LAT    = csa_lat(NSLICE, GROUP);
  localparam int unsigned MSB    = WIDTH - 1;

  if (!csa_params_ok(WIDTH, BLOCK, GROUP)) begin : g_bad_params
    $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK and 1 <= GROUP <= WIDTH/BLOCK");
  end

  // Stage payload: skewed operands (B already conditionally inverted), partial sum, carry.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             ovf;
  } stage_t;

  stage_t           stage_in [LAT];
  stage_t           st_d     [LAT];
  stage_t           st_q     [LAT];
  logic [LAT-1:0]   v_q;
  logic [LAT-1:0]   v_d;
  logic [LAT:0]     adv;
  logic [WIDTH-1:0] slice_sum;
  logic [NSLICE-1:0] slice_cout;

  // Stage 0 sees the ports; later stages see the previous stage register.
  always_comb begin
    stage_in[0].a   = i_add_term1;
    stage_in[0].bx  = i_sub ? ~i_add_term2 : i_add_term2;
    stage_in[0].sum = '0;
    stage_in[0].c   = i_carry ^ i_sub;
    stage_in[0].ovf = 1'b0;
    for (int k = 1; k < int'(LAT); k++) begin
      stage_in[k] = st_q[k-1];
    end
  end

  for (genvar j = 0; j < int'(NSLICE); j++) begin : g_slice
    localparam int unsigned STG = j / GROUP;
    logic             cin_w;
    logic             cout_w;
    logic [BLOCK-1:0] sum_w;

    if (j % GROUP == 0) begin : g_head
      assign cin_w = stage_in[STG].c;
    end else begin : g_chain
      assign cin_w = g_slice[j-1].cout_w;
    end

    csa_slice #(
      .BLOCK (BLOCK),
      .DUAL  (j != 0)
    ) u_slice (
      .a    (stage_in[STG].a[j*BLOCK +: BLOCK]),
      .b    (stage_in[STG].bx[j*BLOCK +: BLOCK]),
      .cin  (cin_w),
      .sum  (sum_w),
      .cout (cout_w)
    );

    assign slice_sum[j*BLOCK +: BLOCK] = sum_w;
    assign slice_cout[j]               = cout_w;
  end

  // Merge each stage's finished slices and its outgoing carry into the payload.
  always_comb begin
    for (int k = 0; k < int'(LAT); k++) begin
      st_d[k] = stage_in[k];
    end
    for (int j = 0; j < int'(NSLICE); j++) begin
      st_d[j/GROUP].sum[j*BLOCK +: BLOCK] = slice_sum[j*BLOCK +: BLOCK];
      if ((j % GROUP == GROUP - 1) || (j == NSLICE - 1)) begin
        st_d[j/GROUP].c = slice_cout[j];
      end
    end
    st_d[LAT-1].ovf = (st_d[LAT-1].a[MSB] == st_d[LAT-1].bx[MSB]) &&
                      (st_d[LAT-1].sum[MSB] != st_d[LAT-1].a[MSB]);
  end

  // A stage may load when it is empty or its content moves on; empty stages collapse bubbles.
  always_comb begin
    adv      = '0;
    v_d      = v_q;
    adv[LAT] = i_ready;
    for (int k = int'(LAT) - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
    v_d[0] = adv[0] ? i_valid : v_q[0];
    for (int k = 1; k < int'(LAT); k++) begin
      v_d[k] = adv[k] ? v_q[k-1] : v_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        st_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < int'(LAT); k++) begin
        if (adv[k]) begin
          st_q[k] <= st_d[k];
        end
      end
    end
  end

  assign o_ready = adv[0];
  assign o_valid = v_q[LAT-1];
  assign o_sum   = st_q[LAT-1].sum;
  assign o_cout  = st_q[LAT-1].c;
  assign o_ovf   = st_q[LAT-1].ovf;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed table at defaults, backpressure, bubbles, reset,
// plus random sweeps of two other parameter sets against an integer reference model.
module tb_csa_pipe_adder;

  localparam int unsigned W   = 12;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] a, b;
  logic         carry, sub, vld, rdy;
  logic         o_ready, o_cout, o_ovf, o_valid;
  logic [W-1:0] o_sum;

  csa_pipe_adder #(.WIDTH(12), .BLOCK(4), .GROUP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_add_term1(a), .i_add_term2(b), .i_carry(carry),
    .i_sub(sub), .i_valid(vld), .o_ready(o_ready), .o_sum(o_sum), .o_cout(o_cout),
    .o_ovf(o_ovf), .o_valid(o_valid), .i_ready(rdy)
  );

  logic [31:0] a32, b32, s32_sum;
  logic        c32, sb32, v32, r32_o, co32, ov32, ov32_v;
  csa_pipe_adder #(.WIDTH(32), .BLOCK(8), .GROUP(2)) u_w32 (
    .clk(clk), .rst_n(rst_n), .i_add_term1(a32), .i_add_term2(b32), .i_carry(c32),
    .i_sub(sb32), .i_valid(v32), .o_ready(r32_o), .o_sum(s32_sum), .o_cout(co32),
    .o_ovf(ov32), .o_valid(ov32_v), .i_ready(1'b1)
  );

  logic [15:0] a16, b16, s16_sum;
  logic        c16, sb16, v16, r16_o, co16, ov16, ov16_v;
  csa_pipe_adder #(.WIDTH(16), .BLOCK(4), .GROUP(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .i_add_term1(a16), .i_add_term2(b16), .i_carry(c16),
    .i_sub(sb16), .i_valid(v16), .o_ready(r16_o), .o_sum(s16_sum), .o_cout(co16),
    .o_ovf(ov16), .o_valid(ov16_v), .i_ready(1'b1)
  );

  int checks = 0;
  int errors = 0;
  int taken  = 0;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [11:0] a, b;
    logic        cy, sb;
    logic [11:0] sum;
    logic        cout, ovf;
  } vec_t;

  res_t exp_q[$];
  res_t q32[$];
  res_t q16[$];

  // Reference: unsigned sum for result/carry, exact signed sum for overflow.
  function automatic res_t golden(input int unsigned w, input logic [63:0] av,
                                  input logic [63:0] bv, input logic cy, input logic sb);
    longint unsigned mask, bp, full;
    longint          sa, sbp, ex, lim;
    res_t            r;
    mask = (64'd1 << w) - 64'd1;
    bp   = sb ? (mask - (bv & mask)) : (bv & mask);
    full = (av & mask) + bp + longint'(cy ^ sb);
    lim  = longint'(64'd1 << (w - 1));
    sa   = longint'(av & mask);
    if (sa >= lim) sa = sa - 2 * lim;
    sbp  = longint'(bp);
    if (sbp >= lim) sbp = sbp - 2 * lim;
    ex     = sa + sbp + longint'(cy ^ sb);
    r.sum  = full & mask;
    r.cout = ((full >> w) & 64'd1) != 64'd0;
    r.ovf  = (ex >= lim) || (ex < -lim);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One cycle on the default DUT with scoreboard bookkeeping; returns whether input was accepted.
  task automatic step(input string tag, output bit acc);
    res_t e;
    #1;
    acc = vld && o_ready;
    if (o_valid && rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: unexpected output %0h with empty scoreboard", tag, o_sum);
      end else begin
        e = exp_q.pop_front();
        chk(tag, {o_cout, o_ovf, o_sum}, {e.cout, e.ovf, e.sum[W-1:0]});
        taken++;
      end
    end
    if (acc) exp_q.push_back(golden(W, 64'(a), 64'(b), carry, sub));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tv[12];
    res_t e;
    bit   acc;
    int   sent, first32, first16;
    bit   have;

    tv[0]  = '{12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};
    tv[1]  = '{12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
    tv[2]  = '{12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0};
    tv[3]  = '{12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1};
    tv[4]  = '{12'h010, 12'h003, 1'b1, 1'b1, 12'h00C, 1'b1, 1'b0};
    tv[5]  = '{12'h123, 12'h456, 1'b1, 1'b0, 12'h57A, 1'b0, 1'b0};
    tv[6]  = '{12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
    tv[7]  = '{12'h0F0, 12'h00F, 1'b1, 1'b0, 12'h100, 1'b0, 1'b0};
    tv[8]  = '{12'hFFF, 12'hFFF, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0};
    tv[9]  = '{12'h000, 12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
    tv[10] = '{12'h7FF, 12'hFFF, 1'b0, 1'b1, 12'h800, 1'b0, 1'b1};
    tv[11] = '{12'h0AB, 12'hF55, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};

    rst_n = 1'b0;
    a = '0; b = '0; carry = 1'b0; sub = 1'b0; vld = 1'b0; rdy = 1'b1;
    a32 = '0; b32 = '0; c32 = 1'b0; sb32 = 1'b0; v32 = 1'b0;
    a16 = '0; b16 = '0; c16 = 1'b0; sb16 = 1'b0; v16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_state", {o_valid, o_ready, o_cout, o_ovf, o_sum}, {1'b0, 1'b1, 1'b0, 1'b0, 12'h000});

    // Back-to-back directed vectors; result n is due LAT cycles after its accept.
    for (int n = 0; n < 12 + int'(LAT); n++) begin
      if (n < 12) begin
        a = tv[n].a; b = tv[n].b; carry = tv[n].cy; sub = tv[n].sb; vld = 1'b1;
      end else begin
        vld = 1'b0;
      end
      #1;
      chk("tbl_ready", 64'(o_ready), 64'd1);
      @(posedge clk);
      #1;
      if (n >= int'(LAT) - 1 && n - (int'(LAT) - 1) < 12) begin
        chk($sformatf("tbl_vec%0d", n - (int'(LAT) - 1)), {o_valid, o_cout, o_ovf, o_sum},
            {1'b1, tv[n-(LAT-1)].cout, tv[n-(LAT-1)].ovf, tv[n-(LAT-1)].sum});
      end else begin
        chk("tbl_no_valid", 64'(o_valid), 64'd0);
      end
    end

    // Backpressure: 8 adds, i_ready low for 5 cycles once the first result shows.
    exp_q.delete();
    sent = 0;
    taken = 0;
    for (int t = 0; t < 60 && (sent < 8 || exp_q.size() != 0); t++) begin
      rdy = !(t >= 3 && t < 8);
      vld = (sent < 8);
      a = 12'(12'h0F0 + sent * 37);
      b = 12'(sent * 251);
      carry = 1'b0;
      sub = 1'b0;
      #1;
      if (t >= 3 && t < 8) begin
        chk("bp_ready_low", 64'(o_ready), 64'd0);
        if (t == 3) chk("bp_held_count", 64'(exp_q.size()), 64'd3);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("bp_hold", {o_valid, o_cout, o_ovf, o_sum}, {1'b1, e.cout, e.ovf, e.sum[W-1:0]});
        end
      end
      step("bp_out", acc);
      if (acc) sent++;
    end
    chk("bp_count", 64'(taken), 64'd8);

    // Bubbles with random downstream ready.
    exp_q.delete();
    sent = 0;
    taken = 0;
    have = 1'b0;
    for (int t = 0; t < 400 && (sent < 30 || exp_q.size() != 0); t++) begin
      if (!have) begin
        a = 12'($urandom); b = 12'($urandom);
        carry = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        have = (sent < 30) && (t % 2 == 0);
      end
      vld = have;
      rdy = 1'($urandom_range(0, 1));
      step("bub_out", acc);
      if (acc) begin
        sent++;
        have = 1'b0;
      end
    end
    chk("bub_count", 64'(taken), 64'd30);

    // Reset with three transactions in flight.
    exp_q.delete();
    rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 12'(12'h111 * (k + 1)); b = 12'h222; carry = 1'b0; sub = 1'b0; vld = 1'b1;
      step("rst_pre", acc);
    end
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {o_valid, o_ready, o_cout, o_ovf, o_sum}, {1'b0, 1'b1, 1'b0, 1'b0, 12'h000});
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_first_cycle", 64'(o_valid), 64'd0);
    for (int n = 0; n < int'(LAT); n++) begin
      vld = (n == 0);
      a = 12'h3A5; b = 12'h05A; carry = 1'b0; sub = 1'b0;
      @(posedge clk);
      #1;
      if (n < int'(LAT) - 1) chk("rst_post_empty", 64'(o_valid), 64'd0);
      else chk("rst_post_result", {o_valid, o_cout, o_ovf, o_sum}, {1'b1, 1'b0, 1'b0, 12'h3FF});
    end
    vld = 1'b0;
    @(posedge clk);
    #1;

    // Random sweeps of the 32/8/2 and 16/4/4 configurations in parallel.
    first32 = -1;
    first16 = -1;
    v32 = 1'b1;
    v16 = 1'b1;
    for (int t = 0; t < 10000; t++) begin
      a32 = $urandom; b32 = $urandom;
      c32 = 1'($urandom_range(0, 1)); sb32 = 1'($urandom_range(0, 1));
      a16 = 16'($urandom); b16 = 16'($urandom);
      c16 = 1'($urandom_range(0, 1)); sb16 = 1'($urandom_range(0, 1));
      #1;
      if (ov32_v) begin
        if (first32 < 0) first32 = t;
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL w32: unexpected output %0h", s32_sum);
        end else begin
          e = q32.pop_front();
          chk("w32", {co32, ov32, s32_sum}, {e.cout, e.ovf, e.sum[31:0]});
        end
      end
      if (ov16_v) begin
        if (first16 < 0) first16 = t;
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL w16: unexpected output %0h", s16_sum);
        end else begin
          e = q16.pop_front();
          chk("w16", {co16, ov16, s16_sum}, {e.cout, e.ovf, e.sum[15:0]});
        end
      end
      if (r32_o) q32.push_back(golden(32, 64'(a32), 64'(b32), c32, sb32));
      if (r16_o) q16.push_back(golden(16, 64'(a16), 64'(b16), c16, sb16));
      @(posedge clk);
      #1;
    end
    chk("w32_latency", 64'(first32), 64'd2);
    chk("w16_latency", 64'(first16), 64'd1);
    v32 = 1'b0;
    v16 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed-width combinational carry-select adders in the adder library.
- Operands are split into BLOCK-bit slices. Each slice precomputes its sum for carry-in 0 and for carry-in 1, then selects one using the incoming carry.
- Pipeline registers are inserted after every GROUP slices.
- A valid/ready handshake on both sides lets the block sit in a stallable datapath.

Parameters:
- WIDTH, 12: operand width. Must be a multiple of BLOCK; elaboration error otherwise.
- BLOCK, 4: slice width in bits.
- GROUP, 1: slices per pipeline stage. Must satisfy 1 <= GROUP <= WIDTH/BLOCK.
- Derived, NSLICE = WIDTH/BLOCK: number of slices.
- Derived, LAT = ceil(NSLICE/GROUP): number of stages, equal to the latency in cycles.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_add_term1, in, WIDTH: operand A.
- i_add_term2, in, WIDTH: operand B.
- i_carry, in, 1: carry-in (borrow-in when subtracting).
- i_sub, in, 1: 0 = add, 1 = subtract.
- i_valid, in, 1: input transaction valid.
- o_ready, out, 1: block can accept an input this cycle.
- o_sum, out, WIDTH: result.
- o_cout, out, 1: carry-out (not-borrow when subtracting).
- o_ovf, out, 1: signed two's-complement overflow.
- o_valid, out, 1: output valid.
- i_ready, in, 1: downstream ready.

Behaviour:
- Single clock domain. rst_n asserts asynchronously and deasserts synchronously to clk (the synchronizer is external).
- Reset: every stage valid bit = 0, so o_valid = 0 and o_ready = 1. o_sum, o_cout and o_ovf reset to 0. Data registers need not be reset internally, but the outputs must read 0 while o_valid = 0 after reset.
- Arithmetic:
  - B' = i_sub ? ~i_add_term2 : i_add_term2.
  - cin = i_carry ^ i_sub.
  - {o_cout, o_sum} = A + B' + cin, truncated to WIDTH+1 bits.
  - o_ovf = (A[msb] == B'[msb]) && (o_sum[msb] != A[msb]).
- Slice operation:
  - Each slice computes s0/c0 with carry-in 0 and s1/c1 with carry-in 1.
  - The selected carry-out is c0 | (c1 & cin_slice).
  - Slice 0 uses cin directly, with no duplicate pair required.
- Pipeline structure:
  - Stage k holds slices [k*GROUP, min((k+1)*GROUP, NSLICE)).
  - Stage k latches the finished lower sum bits, the inter-stage carry, and the still-unused upper operand bits plus the B' inversion.
  - Operand skew registers carry the upper bits forward.
  - Stage LAT-1 drives the outputs from registers. There is no combinational path from inputs to o_sum, o_cout, o_ovf or o_valid.
- Latency: an accepted input (i_valid && o_ready) appears on the outputs exactly LAT cycles later, provided there is no stall. Defaults give 3 cycles.
- Handshake:
  - Stage k advances when !v[k] || adv[k+1], where adv[LAT] = i_ready.
  - o_ready = !v[0] || adv[1].
  - Full throughput is one transaction per cycle.
  - A stall (i_ready = 0 with o_valid = 1) holds o_sum, o_cout, o_ovf and o_valid stable until the output is taken. Bubbles collapse: an empty stage accepts from upstream even during a downstream stall.
- Ordering: in-order. No reordering, no drops, no duplicates. At most LAT transactions in flight.
- Boundary conditions:
  - o_valid must not toggle while i_ready = 0.
  - i_valid = 0 creates a bubble with no data effect.
  - Reset mid-operation discards all in-flight transactions; o_valid is 0 in the first cycle after deassertion.
  - A simultaneous accept and output-take in the same cycle is legal and preserves throughput.
- Wrap-around: 0xFFF + 0x001 gives o_sum = 0x000, o_cout = 1.

Decomposition:
- Package csa_pkg holds:
  - a function or localparam for LAT = (NSLICE+GROUP-1)/GROUP;
  - a parameter-legality check macro or function;
  - the stage payload struct, parameterised by WIDTH through the localparams.
- Sub-module csa_slice: combinational BLOCK-bit dual ripple-carry pair plus carry/sum mux.
  - Ports: a, b, cin, sum, cout.
  - It is instantiated NSLICE times.
  - The stage, skew and handshake logic stays in csa_pipe_adder.

Test Plan:
- Defaults (12/4/1), stream with i_ready = 1:
  - 0x7FF+0x001 gives sum 0x800, cout 0, ovf 1.
  - 0xFFF+0x001 gives sum 0x000, cout 1, ovf 0.
  - Each result appears 3 cycles after acceptance, one result per cycle.
- Subtract:
  - 0x005-0x007 with i_carry = 0 gives sum 0xFFE, cout 0.
  - 0x800-0x001 gives sum 0x7FF, ovf 1.
  - 0x010-0x003 with i_carry = 1 gives sum 0x00C, cout 1.
- Backpressure, 8 back-to-back adds:
  - Hold i_ready = 0 for 5 cycles mid-stream.
  - o_ready drops after 3 transactions are held.
  - Outputs stay stable during the stall, then all 8 results emerge in order with no loss.
- Bubbles: alternate i_valid on and off with i_ready random 50%; a scoreboard matches every result against a golden A+B'+cin model.
- Reset: assert rst_n = 0 for 1 cycle while 3 transactions are in flight. o_valid = 0 immediately and the outputs read 0; the next accepted input yields a correct result 3 cycles later.
- Parameter sweep, random operands 10k each, checked against the golden model:
  - WIDTH = 32, BLOCK = 8, GROUP = 2 (LAT = 2);
  - WIDTH = 16, BLOCK = 4, GROUP = 4 (LAT = 1).
